ps2_keycode_rx: RTL and testbench

//  Receives scan codes (set 2) from a PS/2 keyboard, validates each 11-bit frame,

---
 rtl/ps2_keycode_rx.sv | 160 ++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 receiver: sync + glitch filter, 11-bit frame check, make/break/E0 decode to a held HID keycode.
// Latency: strobes 1 Clk after the stop-bit edge, key 1 Clk later. No backpressure: every frame is consumed as it arrives.
module ps2_keycode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [15:0] key,
    output logic        code_valid,
    output logic [7:0]  code_byte,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt, fall;
    logic [FW-1:0] filt_cnt;
    logic [TW-1:0] to_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_q;
    logic          timeout, good_d, err_d;
    logic          ext, brk;
    logic [7:0]    hid;
    state_t        state_q, state_d;

    // A new PS2_CLK level is accepted only after it has differed from the filtered level for FILTER_LEN cycles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            clk_s1 <= PS2_CLK;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_DAT;
            dat_s2 <= dat_s1;
            fall   <= 1'b0;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
                fall     <= ~clk_s2;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign timeout = (state_q != S_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d = state_q;
        good_d  = 1'b0;
        err_d   = 1'b0;
        if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else if (fall) begin
            case (state_q)
                S_IDLE:   if (!dat_s2) state_d = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP: begin
                    state_d = S_IDLE;
                    if (dat_s2 && (^{shift, par_q})) good_d = 1'b1;
                    else                             err_d  = 1'b1;
                end
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            to_cnt  <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fall || state_q == S_IDLE) to_cnt <= '0;
            else if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + TW'(1);
            if (fall) begin
                case (state_q)
                    S_IDLE:   bit_cnt <= '0;
                    S_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: par_q <= dat_s2;
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        hid = 8'h00;
        case ({ext, code_byte})
            9'h01D:  hid = 8'h1A;
            9'h01C:  hid = 8'h04;
            9'h01B:  hid = 8'h16;
            9'h023:  hid = 8'h07;
            9'h029:  hid = 8'h2C;
            9'h175:  hid = 8'h52;
            9'h172:  hid = 8'h51;
            9'h16B:  hid = 8'h50;
            9'h174:  hid = 8'h4F;
            default: hid = 8'h00;
        endcase
    end

    // Prefixes live until the next non-prefix byte or any frame error, so a dropped byte cannot misprefix.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            code_byte  <= 8'h00;
            key        <= 16'h0000;
            ext        <= 1'b0;
            brk        <= 1'b0;
        end else begin
            code_valid <= good_d;
            frame_err  <= err_d;
            if (good_d) code_byte <= shift;
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (code_valid) begin
                if (code_byte == 8'hE0) begin
                    ext <= 1'b1;
                end else if (code_byte == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (hid != 8'h00) begin
                        if (!brk)                 key <= {8'h00, hid};
                        else if (key[7:0] == hid) key <= 16'h0000;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: directed PS/2 frames, a byte-level key model checked every cycle, plus literal spot checks.
module tb_ps2_keycode_rx;

    localparam int TO   = 1000;
    localparam int HALF = 20;

    logic        Clk, Reset, PS2_CLK, PS2_DAT;
    logic [15:0] key;
    logic        code_valid, frame_err;
    logic [7:0]  code_byte;

    ps2_keycode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .key(key), .code_valid(code_valid), .code_byte(code_byte), .frame_err(frame_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {logic err; logic [7:0] b;} ev_t;
    ev_t         q[$];
    logic [7:0]  hid_tab [logic [8:0]];
    logic [15:0] mkey;
    bit          mext, mbrk;
    int          total = 0;
    int          bad   = 0;

    task automatic fail(input string n, input logic [15:0] a, input logic [15:0] w);
        bad++;
        if (bad <= 30) $display("FAIL %s: got %h expected %h at %0t", n, a, w, $time);
    endtask

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] w);
        total++;
        if (a !== w) fail(n, a, w);
    endtask

    // Model works on whole received bytes: the key only depends on the byte sequence and the prefix rules.
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] h;
        if (b == 8'hE0) mext = 1;
        else if (b == 8'hF0) mbrk = 1;
        else begin
            h = hid_tab.exists({mext, b}) ? hid_tab[{mext, b}] : 8'h00;
            if (h != 8'h00) begin
                if (!mbrk) mkey = {8'h00, h};
                else if (mkey[7:0] == h) mkey = 16'h0000;
            end
            mext = 0;
            mbrk = 0;
        end
    endtask

    always @(negedge Clk) begin
        ev_t e;
        if (!Reset) begin
            chk("key", key, mkey);
            if (code_valid && frame_err) fail("both_strobes", 16'h1, 16'h0);
            if (code_valid || frame_err) begin
                total++;
                if (q.size() == 0) begin
                    fail("unexpected_strobe", {7'h0, frame_err, code_byte}, 16'h0);
                end else begin
                    e = q.pop_front();
                    if (frame_err) begin
                        if (!e.err) fail("frame_err", {7'h0, frame_err, code_byte}, {7'h0, e});
                        mext = 0;
                        mbrk = 0;
                    end else begin
                        if (e.err || code_byte !== e.b) fail("code_valid", {7'h0, frame_err, code_byte}, {7'h0, e});
                        else model_byte(e.b);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_after);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = bits[i];
            tick(HALF);
            PS2_CLK = 1'b0;
            tick(HALF);
            PS2_CLK = 1'b1;
            if (i == glitch_after) begin
                tick(4);
                PS2_CLK = 1'b0;
                tick(3);
                PS2_CLK = 1'b1;
            end
        end
        tick(HALF);
        PS2_DAT = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        q.push_back({1'b0, b});
        send_bits(mk(b, 0, 0), 11, -1);
        tick(10);
    endtask

    initial begin
        hid_tab[9'h01D] = 8'h1A; hid_tab[9'h01C] = 8'h04; hid_tab[9'h01B] = 8'h16;
        hid_tab[9'h023] = 8'h07; hid_tab[9'h029] = 8'h2C; hid_tab[9'h175] = 8'h52;
        hid_tab[9'h172] = 8'h51; hid_tab[9'h16B] = 8'h50; hid_tab[9'h174] = 8'h4F;
        mkey = 16'h0000; mext = 0; mbrk = 0;
        Reset = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1;
        tick(5);
        Reset = 1'b0;
        tick(5);
        chk("rst_key", key, 16'h0000);
        chk("rst_code_byte", {8'h00, code_byte}, 16'h0000);
        chk("rst_strobes", {14'h0, code_valid, frame_err}, 16'h0000);

        send(8'h1D);
        chk("lit_1D_byte", {8'h00, code_byte}, 16'h001D);
        chk("lit_1D_key", key, 16'h001A);
        send(8'hF0); send(8'h1D);
        chk("lit_break_1D", key, 16'h0000);
        send(8'h23);
        send(8'hF0); send(8'h1C);
        chk("lit_break_nonheld", key, 16'h0007);

        q.push_back({1'b1, 8'h00});
        send_bits(mk(8'h1D, 1, 0), 11, -1);
        tick(10);
        chk("lit_parity_err_key", key, 16'h0007);

        send(8'h1C); send(8'h1C);
        chk("lit_repeat", key, 16'h0004);
        send(8'hE0); send(8'h75);
        chk("lit_E0_75", key, 16'h0052);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("lit_E0_F0_75", key, 16'h0000);
        send(8'hE0); send(8'h72);
        send(8'hF0); send(8'h72);
        chk("lit_break_unmapped", key, 16'h0051);

        send(8'h23);
        send(8'hE0);
        q.push_back({1'b1, 8'h00});
        send_bits(mk(8'h11, 0, 1), 11, -1);
        tick(10);
        send(8'hF0); send(8'h23);
        chk("lit_err_clears_ext", key, 16'h0000);

        send(8'h29);
        send(8'hF0);
        q.push_back({1'b1, 8'h00});
        send_bits(mk(8'h55, 0, 0), 5, -1);
        tick(TO + 100);
        chk("lit_timeout_drained", q.size(), 16'h0000);
        send(8'h1B);
        chk("lit_after_timeout", key, 16'h0016);

        q.push_back({1'b0, 8'h23});
        send_bits(mk(8'h23, 0, 0), 11, 3);
        tick(10);
        chk("lit_glitch", key, 16'h0007);

        send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'h74);
        chk("lit_E0_74", key, 16'h004F);
        send(8'hE0); send(8'hF0); send(8'h74);

        send(8'h1D);
        send_bits(mk(8'h23, 0, 0), 5, -1);
        Reset = 1'b1;
        q.delete();
        mkey = 16'h0000; mext = 0; mbrk = 0;
        tick(3);
        chk("midrst_key", key, 16'h0000);
        chk("midrst_byte", {8'h00, code_byte}, 16'h0000);
        chk("midrst_strobes", {14'h0, code_valid, frame_err}, 16'h0000);
        Reset = 1'b0;
        tick(50);
        send(8'h23);
        chk("lit_after_reset", key, 16'h0007);

        tick(20);
        chk("events_left", q.size(), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
